// File: rtl/inst_sequencer_if.sv
// Bundle of the sequencer's request, status and core-instruction signals.
// start is a single-cycle request with no ready: acceptance shows as busy, rejection as an err pulse.
interface inst_sequencer_if;
   logic        start;
   logic [3:0]  kij;
   logic        ofifo_valid;
   logic [33:0] inst;
   logic        busy;
   logic        done;
   logic        err;
   logic [2:0]  dbg_state;

   modport master (
      output start, kij, ofifo_valid,
      input  inst, busy, done, err, dbg_state
   );

   modport slave (
      input  start, kij, ofifo_valid,
      output inst, busy, done, err, dbg_state
   );
endinterface

// File: rtl/inst_sequencer.sv
// Sequences one kij pass of the PE core: weight fetch/load, gap, activation fetch, execute, psum drain.
// All outputs are registered, so every status bit lines up with the instruction word it describes.
module inst_sequencer #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int len_nij = 36,
   parameter int gap     = 10
) (
   input  logic              clk,
   input  logic              reset,
   inst_sequencer_if.slave   bus
);

   localparam logic [33:0] IDLE_WORD   = 34'h1800C0000;
   localparam logic [6:0]  FETCH_LAST  = 7'(col - 1);
   localparam logic [6:0]  LOAD_LAST   = 7'(row + 2 * col - 1);
   localparam logic [6:0]  GAP_LAST    = 7'(gap - 1);
   localparam logic [6:0]  NIJ_LAST    = 7'(len_nij - 1);
   localparam logic [6:0]  EXEC_LAST   = 7'(len_nij + row + col - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_W_FETCH = 3'd1,
      S_W_LOAD  = 3'd2,
      S_GAP     = 3'd3,
      S_X_FETCH = 3'd4,
      S_EXEC    = 3'd5,
      S_DRAIN   = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [6:0]  r_cnt;
   logic [3:0]  r_kij;
   logic        w_start_ok;
   logic [10:0] w_pmem_addr;
   logic [33:0] w_inst;
   logic        w_busy;
   logic        w_done;
   logic        w_err;
   logic [33:0] r_inst;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   assign w_start_ok  = bus.start && (bus.kij <= 4'd8);
   assign w_pmem_addr = 11'(len_nij) * {7'd0, r_kij} + {4'd0, r_cnt};

   // State register; in DRAIN the counter only advances on an actual psum write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 7'd0;
         r_kij   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= 7'd0;
         else if (r_state == S_DRAIN)
            r_cnt <= r_cnt + {6'd0, bus.ofifo_valid};
         else if (r_state != S_IDLE)
            r_cnt <= r_cnt + 7'd1;
         if (r_state == S_IDLE && w_start_ok)
            r_kij <= bus.kij;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start_ok)            w_next = S_W_FETCH;
         S_W_FETCH: if (r_cnt == FETCH_LAST)   w_next = S_W_LOAD;
         S_W_LOAD:  if (r_cnt == LOAD_LAST)    w_next = S_GAP;
         S_GAP:     if (r_cnt == GAP_LAST)     w_next = S_X_FETCH;
         S_X_FETCH: if (r_cnt == NIJ_LAST)     w_next = S_EXEC;
         S_EXEC:    if (r_cnt == EXEC_LAST)    w_next = S_DRAIN;
         S_DRAIN:   if (bus.ofifo_valid && r_cnt == NIJ_LAST) w_next = S_DONE;
         S_DONE:                               w_next = S_IDLE;
         default:                              w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_inst = IDLE_WORD;
      w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
      w_done = (r_state == S_DONE);
      w_err  = (r_state == S_IDLE) && bus.start && !w_start_ok;
      case (r_state)
         S_W_FETCH: begin
            w_inst[19]   = 1'b0;
            w_inst[17:7] = 11'd1024 + {4'd0, r_cnt};
            w_inst[5]    = 1'b1;
         end
         S_W_LOAD: begin
            w_inst[4] = 1'b1;
            w_inst[0] = 1'b1;
         end
         S_X_FETCH: begin
            w_inst[19]   = 1'b0;
            w_inst[17:7] = {4'd0, r_cnt};
            w_inst[2]    = 1'b1;
         end
         S_EXEC: begin
            w_inst[3] = 1'b1;
            w_inst[1] = 1'b1;
         end
         S_DRAIN: begin
            if (bus.ofifo_valid) begin
               w_inst[32]    = 1'b0;
               w_inst[31]    = 1'b0;
               w_inst[30:20] = w_pmem_addr;
               w_inst[6]     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_inst <= IDLE_WORD;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_inst <= w_inst;
         r_busy <= w_busy;
         r_done <= w_done;
         r_err  <= w_err;
      end
   end

   assign bus.inst      = r_inst;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: each pass is predicted as a list of per-cycle words built from the
// phase lengths, then compared cycle by cycle against {err, done, busy, inst}.
module tb_inst_sequencer;

   localparam logic [33:0] IDLE_W = 34'h1800C0000;
   localparam int W = 37;

   logic clk;
   logic reset;
   inst_sequencer_if bus ();

   inst_sequencer #(.row(8), .col(8), .len_nij(36), .gap(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] exp_q[$];
   bit           vpat[0:511];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           exp_busy;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pk(input logic [33:0] i, input bit b, input bit d, input bit e);
      return {e, d, b, i};
   endfunction

   function automatic logic [33:0] xmem_word(input int addr, input bit to_l0);
      logic [33:0] w;
      w        = IDLE_W;
      w[19]    = 1'b0;
      w[17:7]  = 11'(addr);
      if (to_l0) w[2] = 1'b1;
      else       w[5] = 1'b1;
      return w;
   endfunction

   function automatic logic [33:0] pmem_word(input int addr);
      logic [33:0] w;
      w        = IDLE_W;
      w[32]    = 1'b0;
      w[31]    = 1'b0;
      w[30:20] = 11'(addr);
      w[6]     = 1'b1;
      return w;
   endfunction

   // Valid pattern per cycle index; mode 0 always 1, mode 1 repeats 1,0,0, mode 2 random.
   task automatic build_model(input int k, input int vmode);
      int c;
      int writes;
      logic [33:0] ld_w;
      logic [33:0] ex_w;
      for (int i = 0; i < 512; i++) begin
         case (vmode)
            0:       vpat[i] = 1'b1;
            1:       vpat[i] = ((i - 131) % 3 == 0);
            default: vpat[i] = 1'($urandom_range(0, 1));
         endcase
         if (i >= 400) vpat[i] = 1'b1;
      end
      ld_w = IDLE_W; ld_w[4] = 1'b1; ld_w[0] = 1'b1;
      ex_w = IDLE_W; ex_w[3] = 1'b1; ex_w[1] = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 8; i++)  exp_q.push_back(pk(xmem_word(1024 + i, 1'b0), 1, 0, 0));
      for (int i = 0; i < 24; i++) exp_q.push_back(pk(ld_w, 1, 0, 0));
      for (int i = 0; i < 10; i++) exp_q.push_back(pk(IDLE_W, 1, 0, 0));
      for (int i = 0; i < 36; i++) exp_q.push_back(pk(xmem_word(i, 1'b1), 1, 0, 0));
      for (int i = 0; i < 52; i++) exp_q.push_back(pk(ex_w, 1, 0, 0));
      c = 131;
      writes = 0;
      while (writes < 36) begin
         if (vpat[c]) begin
            exp_q.push_back(pk(pmem_word(36 * k + writes), 1, 0, 0));
            writes++;
         end else begin
            exp_q.push_back(pk(IDLE_W, 1, 0, 0));
         end
         c++;
      end
      exp_busy = exp_q.size();
      exp_q.push_back(pk(IDLE_W, 0, 1, 0));
      exp_q.push_back(pk(IDLE_W, 0, 0, 0));
   endtask

   // inj_c: cycle carrying an extra start (kij=2) that must be ignored; -1 means the done cycle.
   // abort_c: cycle in which reset is asserted, abandoning the pass.
   task automatic run_pass(input int k, input int vmode, input int inj_c, input int abort_c);
      int n;
      int inj;
      int busy_cnt;
      int done_cnt;
      logic [W-1:0] obs;
      logic [W-1:0] exp;
      build_model(k, vmode);
      n        = exp_q.size();
      inj      = (inj_c < 0) ? n - 1 : inj_c;
      busy_cnt = 0;
      done_cnt = 0;
      @(negedge clk);
      reset           = 1'b0;
      bus.start       = 1'b1;
      bus.kij         = 4'(k);
      bus.ofifo_valid = 1'b1;
      @(posedge clk); #1;
      check("accept", {bus.err, bus.done, bus.busy, bus.inst}, pk(IDLE_W, 0, 0, 0));
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         bus.start       = (c == inj);
         bus.kij         = 4'd2;
         bus.ofifo_valid = vpat[c];
         reset           = (c == abort_c);
         @(posedge clk); #1;
         obs = {bus.err, bus.done, bus.busy, bus.inst};
         if (c == abort_c) begin
            check("abort", obs, pk(IDLE_W, 0, 0, 0));
            exp_q.delete();
            break;
         end
         exp = exp_q.pop_front();
         check($sformatf("kij%0d_c%0d", k, c), obs, exp);
         busy_cnt += int'(bus.busy);
         done_cnt += int'(bus.done);
      end
      if (abort_c == 0) begin
         check("busy_cycles", W'(busy_cnt), W'(exp_busy));
         check("done_pulses", W'(done_cnt), W'(1));
      end
      @(negedge clk);
      bus.start = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic bad_start(input logic [3:0] k);
      @(negedge clk);
      bus.start = 1'b1;
      bus.kij   = k;
      @(posedge clk); #1;
      check("err_pulse", {bus.err, bus.done, bus.busy, bus.inst}, pk(IDLE_W, 0, 0, 1));
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("err_clear", {bus.err, bus.done, bus.busy, bus.inst}, pk(IDLE_W, 0, 0, 0));
   endtask

   initial begin
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.kij         = 4'd0;
      bus.ofifo_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("reset", {bus.err, bus.done, bus.busy, bus.inst}, pk(IDLE_W, 0, 0, 0));

      run_pass(0, 0, 0, 0);
      run_pass(8, 0, 0, 0);
      run_pass(5, 1, 0, 0);
      bad_start(4'd9);
      bad_start(4'd15);
      run_pass(2, 2, 99, 0);
      run_pass(7, 0, -1, 0);
      run_pass(4, 0, 0, 99);
      run_pass(3, 0, 0, 0);
      repeat (3) run_pass($urandom_range(0, 8), 2, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameters: row 8 (PE rows / ic); col 8 (PE cols / oc); len_nij 36 (input pixels per tile); gap 10 (idle cycles after kernel load).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high.
REQ-004 SHALL have port: start  input  1  one-cycle request to run one kij pass.
REQ-005 SHALL have port: kij  input  4  kernel index 0..8, sampled with start.
REQ-006 SHALL have port: ofifo_valid  input  1  core output FIFO holds a row.
REQ-007 SHALL have port: inst  output  34  registered core instruction word, using the core bit map: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-008 SHALL have port: busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port: done  output  1  one-cycle pulse at end of pass.
REQ-010 SHALL have port: err  output  1  one-cycle pulse when start is rejected.

Function
REQ-011 SHALL implement states IDLE, W_FETCH, W_LOAD, GAP, X_FETCH, EXEC, DRAIN, DONE, each with a cycle counter cleared on entry.
REQ-012 Idle word: CEN_xmem=1, WEN_xmem=1, CEN_pmem=1, WEN_pmem=1, all other bits 0, i.e. inst = 34'h1800C0000; driven in IDLE, GAP and DONE.
REQ-013 IDLE: start with kij<=8 latches kij and enters W_FETCH next cycle; start with kij>8 pulses err, stays IDLE; start while not IDLE is ignored, with no err.
REQ-014 W_FETCH: col cycles; CEN_xmem=0, WEN_xmem=1, ififo_wr=1; A_xmem = 11'd1024 + counter (1024..1031).
REQ-015 W_LOAD: row+2*col cycles (24); ififo_rd=1, load=1; xmem disabled.
REQ-016 GAP: gap cycles (10) at the idle word.
REQ-017 X_FETCH: len_nij cycles; CEN_xmem=0, WEN_xmem=1, l0_wr=1; A_xmem = counter (0..35).
REQ-018 EXEC: len_nij+row+col cycles (52); l0_rd=1, execute=1.
REQ-019 DRAIN: each cycle with ofifo_valid=1 drives ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = len_nij*kij_latched + write count; with ofifo_valid=0 it drives the idle word and holds the count; exits after exactly len_nij writes.
REQ-020 A_pmem product SHALL be computed at 11 bits; max 36*8+35 = 323, no overflow.
REQ-021 DONE: one cycle; done=1, busy=0 in that cycle; then IDLE. A start arriving in the DONE cycle is ignored.
REQ-022 acc (bit 33) SHALL be 0 in all states; accumulation is sequenced elsewhere.
REQ-023 inst SHALL be a registered output: the word for state S, count n appears one cycle after the FSM is in S with count n.

Reset
REQ-024 reset=1 at any clock edge SHALL force state IDLE, counters 0, kij_latched 0, inst=34'h1800C0000, busy=0, done=0, err=0, including mid-pass; the pass is abandoned and not resumed.
REQ-025 After reset deasserts, start SHALL be accepted on the very next edge.

Verification
REQ-026 Reset 5 cycles, then start kij=0 with ofifo_valid held 1 -> ififo_wr for 8 cycles (A_xmem 1024..1031), load 24, gap 10, l0_wr 36 (A_xmem 0..35), execute 52, pmem writes A_pmem 0..35; done exactly 1 cycle.
REQ-027 Start kij=8 with ofifo_valid=1 -> DRAIN A_pmem 288..323; total busy cycles 8+24+10+36+52+36 = 166.
REQ-028 In DRAIN, toggle ofifo_valid 1,0,0,1... -> no ofifo_rd or pmem write while valid=0; addresses stay contiguous; exit only after 36 writes.
REQ-029 Start kij=9 in IDLE -> err pulse, busy stays 0, inst stays 34'h1800C0000; start during EXEC -> ignored, no err.
REQ-030 Assert reset at EXEC cycle 20 -> next cycle inst=34'h1800C0000, busy=0; a subsequent start kij=3 runs a full pass with A_pmem 108..143.
